// File: rtl/uart_dev.sv
// uart_dev: 8N1 UART slave on the system bridge (DEV2), with TX and RX byte FIFOs.
// Optional internal loopback (CTRL[2]) is compiled in when UART_LOOPBACK_EN is defined.
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line high, waiting for TX FIFO data
//   TX_START | driving the start bit (low)
//   TX_DATA  | driving 8 data bits, LSB first
//   TX_STOP  | driving the stop bit (high); chains straight into TX_START if more data
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synchronised line
//   RX_START | half-bit wait, then confirm the start bit is still low
//   RX_DATA  | sampling 8 data bits at bit centres, LSB first
//   RX_STOP  | sampling the stop bit; push the byte or flag a framing error
//   RX_BREAK | framing error seen, waiting for the line to return high

module uart_dev_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       full,
   output logic       empty
);
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          pop_ok;
   logic          push_ok;

   assign empty   = (count == '0);
   assign full    = (count == FULL_CNT);
   assign pop_ok  = pop & ~empty;
   // a pop in the same cycle frees the slot a full FIFO needs for the push
   assign push_ok = push & (~full | pop_ok);
   assign rdata   = mem[rd_ptr];

   // pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: ;
         endcase
      end
   end

   // byte storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wdata;
   end
endmodule

module uart_dev #(
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:2] Addr,
   input  logic        WE,
   input  logic [31:0] Din,
   output logic [31:0] Dout,
   output logic        IRQ,
   input  logic        uart_rxd,
   output logic        uart_txd
);
   typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_BREAK} rx_state_t;

   localparam logic [2:0] A_TXDATA  = 3'd0;
   localparam logic [2:0] A_RXDATA  = 3'd1;
   localparam logic [2:0] A_STATUS  = 3'd2;
   localparam logic [2:0] A_CTRL    = 3'd3;
   localparam logic [2:0] A_DIVISOR = 3'd4;

   logic [2:0]  reg_sel;
   logic        unused_bits;
   logic [15:0] divisor;
   logic [15:0] div_eff;
   logic        rx_ie;
   logic        txe_ie;
   logic        lb_en;
   logic        overrun;
   logic        frame_err;
   logic        status_clr;

   logic        tx_push;
   logic        tx_pop;
   logic        tx_full;
   logic        tx_empty;
   logic [7:0]  tx_head;
   logic        tx_busy;
   tx_state_t   tx_state;
   logic [15:0] tx_cnt;
   logic [15:0] tx_div;
   logic [7:0]  tx_shift;
   logic [2:0]  tx_bit;
   logic        tx_line;

   logic        rx_push;
   logic        rx_pop;
   logic        rx_full;
   logic        rx_empty;
   logic        rx_valid;
   logic        rx_overflow;
   logic        rx_frame_bad;
   logic [7:0]  rx_head;
   rx_state_t   rx_state;
   logic [15:0] rx_cnt;
   logic [15:0] rx_div;
   logic [7:0]  rx_shift;
   logic [2:0]  rx_bit;
   logic        rx_in;
   logic        rx_s1;
   logic        rx_s2;
   logic        rx_prev;

   assign reg_sel     = Addr[4:2];
   assign unused_bits = ^{Addr[31:5], Din[31:16]};
   assign div_eff     = (divisor < 16'd2) ? 16'd2 : divisor;

   assign tx_push    = WE & (reg_sel == A_TXDATA);
   assign rx_pop     = WE & (reg_sel == A_RXDATA);
   assign status_clr = WE & (reg_sel == A_STATUS);

   // control and divisor registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         divisor <= DEFAULT_DIV;
         rx_ie   <= 1'b0;
         txe_ie  <= 1'b0;
      end else if (WE) begin
         if (reg_sel == A_CTRL) begin
            rx_ie  <= Din[0];
            txe_ie <= Din[1];
         end
         if (reg_sel == A_DIVISOR) divisor <= Din[15:0];
      end
   end

`ifdef UART_LOOPBACK_EN
   // loopback enable bit, only present in loopback builds
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                        lb_en <= 1'b0;
      else if (WE && reg_sel == A_CTRL)  lb_en <= Din[2];
   end
`else
   assign lb_en = 1'b0;
`endif

   // sticky error flags; a new event in the clearing cycle wins over the clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (status_clr) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
         end
         if (rx_overflow)  overrun   <= 1'b1;
         if (rx_frame_bad) frame_err <= 1'b1;
      end
   end

   uart_dev_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (Din[7:0]),
      .rdata (tx_head),
      .full  (tx_full),
      .empty (tx_empty)
   );

   assign tx_busy = (tx_state != TX_IDLE);
   // a new frame starts from IDLE or directly at the end of a stop bit
   assign tx_pop  = ~tx_empty &
                    ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_cnt == 16'd0));

   // transmit FSM; tx_cnt is a per-bit down-counter, terminal at zero
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tx_state <= TX_IDLE;
         tx_cnt   <= 16'd0;
         tx_div   <= 16'd0;
         tx_shift <= 8'd0;
         tx_bit   <= 3'd0;
         tx_line  <= 1'b1;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               tx_line <= 1'b1;
               if (tx_pop) begin
                  tx_state <= TX_START;
                  tx_shift <= tx_head;
                  tx_div   <= div_eff;
                  tx_cnt   <= div_eff - 16'd1;
                  tx_line  <= 1'b0;
               end
            end
            TX_START: begin
               if (tx_cnt == 16'd0) begin
                  tx_state <= TX_DATA;
                  tx_cnt   <= tx_div - 16'd1;
                  tx_bit   <= 3'd0;
                  tx_line  <= tx_shift[0];
               end else begin
                  tx_cnt <= tx_cnt - 16'd1;
               end
            end
            TX_DATA: begin
               if (tx_cnt == 16'd0) begin
                  tx_cnt   <= tx_div - 16'd1;
                  tx_shift <= {1'b0, tx_shift[7:1]};
                  if (tx_bit == 3'd7) begin
                     tx_state <= TX_STOP;
                     tx_line  <= 1'b1;
                  end else begin
                     tx_bit  <= tx_bit + 3'd1;
                     tx_line <= tx_shift[1];
                  end
               end else begin
                  tx_cnt <= tx_cnt - 16'd1;
               end
            end
            TX_STOP: begin
               if (tx_cnt == 16'd0) begin
                  if (tx_pop) begin
                     tx_state <= TX_START;
                     tx_shift <= tx_head;
                     tx_div   <= div_eff;
                     tx_cnt   <= div_eff - 16'd1;
                     tx_line  <= 1'b0;
                  end else begin
                     tx_state <= TX_IDLE;
                  end
               end else begin
                  tx_cnt <= tx_cnt - 16'd1;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // in loopback the pin is parked high while the shifter feeds RX internally
   assign uart_txd = tx_line | lb_en;
   assign rx_in    = lb_en ? tx_line : uart_rxd;

   // two-flop synchroniser plus one delayed copy for falling-edge detect
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx_in;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   assign rx_push      = (rx_state == RX_STOP) && (rx_cnt == 16'd0) && rx_s2;
   assign rx_frame_bad = (rx_state == RX_STOP) && (rx_cnt == 16'd0) && !rx_s2;
   assign rx_overflow  = rx_push & rx_full & ~(rx_pop & rx_valid);

   // receive FSM; samples land at bit centres via the half-bit start delay
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_state <= RX_IDLE;
         rx_cnt   <= 16'd0;
         rx_div   <= 16'd0;
         rx_shift <= 8'd0;
         rx_bit   <= 3'd0;
      end else begin
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_s2) begin
                  rx_state <= RX_START;
                  rx_div   <= div_eff;
                  rx_cnt   <= {1'b0, div_eff[15:1]} - 16'd1;
               end
            end
            RX_START: begin
               if (rx_cnt == 16'd0) begin
                  if (rx_s2) begin
                     rx_state <= RX_IDLE;
                  end else begin
                     rx_state <= RX_DATA;
                     rx_cnt   <= rx_div - 16'd1;
                     rx_bit   <= 3'd0;
                  end
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            RX_DATA: begin
               if (rx_cnt == 16'd0) begin
                  rx_shift <= {rx_s2, rx_shift[7:1]};
                  rx_cnt   <= rx_div - 16'd1;
                  if (rx_bit == 3'd7) rx_state <= RX_STOP;
                  else                rx_bit   <= rx_bit + 3'd1;
               end else begin
                  rx_cnt <= rx_cnt - 16'd1;
               end
            end
            RX_STOP: begin
               if (rx_cnt == 16'd0) rx_state <= rx_s2 ? RX_IDLE : RX_BREAK;
               else                 rx_cnt   <= rx_cnt - 16'd1;
            end
            RX_BREAK: begin
               if (rx_s2) rx_state <= RX_IDLE;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   uart_dev_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_push),
      .pop   (rx_pop),
      .wdata (rx_shift),
      .rdata (rx_head),
      .full  (rx_full),
      .empty (rx_empty)
   );

   assign rx_valid = ~rx_empty;
   assign IRQ      = (rx_ie & rx_valid) | (txe_ie & tx_empty & ~tx_busy);

   // read mux
   always_comb begin
      Dout = 32'd0;
      case (reg_sel)
         A_RXDATA:  Dout = {rx_valid, 23'd0, rx_head};
         A_STATUS:  Dout = {25'd0, frame_err, tx_busy, overrun, rx_full, rx_valid, tx_empty, tx_full};
         A_CTRL:    Dout = {29'd0, lb_en, txe_ie, rx_ie};
         A_DIVISOR: Dout = {16'd0, divisor};
         default:   Dout = 32'd0;
      endcase
   end
endmodule

// File: tb/tb_uart_dev.sv
// tb_uart_dev: directed checks of uart_dev framing, FIFOs, flags and IRQ.
module tb_uart_dev;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:2] Addr;
   logic        WE;
   logic [31:0] Din;
   logic [31:0] Dout;
   logic        IRQ;
   logic        uart_rxd;
   logic        uart_txd;

   int checks = 0;
   int errors = 0;
   logic tx_log [0:1499];

   uart_dev dut (
      .clk      (clk),
      .reset    (reset),
      .Addr     (Addr),
      .WE       (WE),
      .Din      (Din),
      .Dout     (Dout),
      .IRQ      (IRQ),
      .uart_rxd (uart_rxd),
      .uart_txd (uart_txd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_write(input logic [2:0] idx, input logic [31:0] d);
      Addr = 30'(idx);
      Din  = d;
      WE   = 1'b1;
      @(negedge clk);
      WE   = 1'b0;
   endtask

   task automatic bus_read(input logic [2:0] idx, output logic [31:0] d);
      Addr = 30'(idx);
      WE   = 1'b0;
      #1;
      d = Dout;
   endtask

   task automatic rx_bits(input logic [7:0] b);
      uart_rxd = 1'b0;
      idle(16);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         idle(16);
      end
   endtask

   task automatic rx_stop(input logic v);
      uart_rxd = v;
      idle(16);
      uart_rxd = 1'b1;
      idle(4);
   endtask

   initial begin
      logic [31:0] rd;
      logic [3:0]  nib;
      logic [9:0]  fexp;
      logic [11:0] fobs;
      logic [11:0] fref;
      logic [7:0]  bb;
      logic        hi_ok;
      int          base;
      int          zeros;

      reset = 1'b0; WE = 1'b0; Addr = '0; Din = '0; uart_rxd = 1'b1;
      idle(3);
      reset = 1'b1;
      idle(2);

      check("rst_txd", 32'(uart_txd), 32'h1);
      check("rst_irq", 32'(IRQ), 32'h0);
      bus_read(3'd2, rd); check("rst_status", rd, 32'h2);
      bus_read(3'd4, rd); check("rst_div", rd, 32'd16);
      bus_read(3'd3, rd); check("rst_ctrl", rd, 32'h0);

      // single 0xA5 frame at 4 clocks per bit
      bus_write(3'd4, 32'd4);
      bus_write(3'd0, 32'hA5);
      check("tx_latency_high", 32'(uart_txd), 32'h1);
      fexp = {1'b1, 8'hA5, 1'b0};
      for (int b = 0; b < 10; b++) begin
         nib = 4'd0;
         for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            nib[s] = uart_txd;
         end
         check($sformatf("tx_a5_bit%0d", b), 32'(nib), 32'({4{fexp[b]}}));
      end
      bus_read(3'd2, rd); check("tx_busy_in_stop", rd, 32'h22);
      idle(1);
      bus_read(3'd2, rd); check("tx_busy_clear", rd, 32'h2);

      // divisor below 2 behaves as 2 clocks per bit
      bus_write(3'd4, 32'd1);
      bus_write(3'd0, 32'hFF);
      nib = 4'd0;
      for (int s = 0; s < 3; s++) begin
         @(negedge clk);
         nib[s] = uart_txd;
      end
      check("tx_div_min", 32'(nib), 32'h4);
      idle(30);

      // 9 back-to-back bytes plus a 10th that must be dropped
      bus_write(3'd4, 32'd16);
      for (int i = 0; i < 10; i++) begin
         bus_write(3'd0, (i < 9) ? 32'(32'h11 + i) : 32'hEE);
         tx_log[i] = uart_txd;
         if (i == 9) begin
            bus_read(3'd2, rd);
            check("tx_fifo_full", rd, 32'h21);
         end
      end
      for (int j = 10; j < 1500; j++) begin
         @(negedge clk);
         tx_log[j] = uart_txd;
      end
      for (int f = 0; f < 9; f++) begin
         base = 1 + 160 * f;
         bb   = 8'(32'h11 + f);
         fobs[0]  = tx_log[base - 1];
         for (int b = 0; b < 10; b++) fobs[b + 1] = tx_log[base + 16 * b + 8];
         fobs[11] = tx_log[base];
         fref = {1'b0, 1'b1, bb, 1'b0, 1'b1};
         check($sformatf("tx_b2b_frame%0d", f), 32'(fobs), 32'(fref));
      end
      zeros = 0;
      for (int j = 1441; j < 1500; j++) if (!tx_log[j]) zeros++;
      check("tx_no_10th_frame", 32'(zeros), 32'd0);
      bus_read(3'd2, rd); check("tx_b2b_done", rd, 32'h2);

      // single received byte with rx interrupt enabled
      bus_write(3'd3, 32'h1);
      check("rx_irq_idle", 32'(IRQ), 32'h0);
      rx_bits(8'h3C);
      check("rx_irq_before_stop", 32'(IRQ), 32'h0);
      rx_stop(1'b1);
      check("rx_irq_after_stop", 32'(IRQ), 32'h1);
      bus_read(3'd1, rd); check("rx_data_3c", rd, 32'h8000003C);
      bus_write(3'd1, 32'h0);
      check("rx_irq_after_pop", 32'(IRQ), 32'h0);
      bus_read(3'd2, rd); check("rx_status_after_pop", rd, 32'h2);

      // overflow the RX FIFO
      for (int i = 0; i < 9; i++) begin
         rx_bits(8'(32'h41 + i));
         rx_stop(1'b1);
      end
      bus_read(3'd2, rd); check("rx_overrun_status", rd, 32'h1E);
      bus_read(3'd1, rd); check("rx_overrun_head", rd, 32'h80000041);

      // framing error: byte discarded, flag set
      rx_bits(8'h77);
      rx_stop(1'b0);
      bus_read(3'd2, rd); check("rx_frame_err_status", rd, 32'h5E);
      bus_read(3'd1, rd); check("rx_frame_err_head", rd, 32'h80000041);
      bus_write(3'd2, 32'h0);
      bus_read(3'd2, rd); check("rx_flags_cleared", rd, 32'h0E);

      for (int i = 0; i < 8; i++) begin
         bus_read(3'd1, rd);
         check($sformatf("rx_drain%0d", i), rd, 32'(32'h80000041 + i));
         bus_write(3'd1, 32'h0);
      end
      bus_read(3'd2, rd); check("rx_drained", rd, 32'h2);

      // quarter-bit glitch must be rejected silently
      uart_rxd = 1'b0;
      idle(4);
      uart_rxd = 1'b1;
      idle(200);
      bus_read(3'd2, rd); check("rx_glitch", rd, 32'h2);
      check("rx_glitch_irq", 32'(IRQ), 32'h0);

      // TX-empty interrupt
      bus_write(3'd3, 32'h2);
      check("txe_irq", 32'(IRQ), 32'h1);
      bus_write(3'd3, 32'h0);
      check("txe_irq_off", 32'(IRQ), 32'h0);

`ifdef UART_LOOPBACK_EN
      bus_write(3'd3, 32'h5);
      bus_read(3'd3, rd); check("lb_ctrl", rd, 32'h5);
      bus_write(3'd0, 32'h5A);
      hi_ok = 1'b1;
      repeat (200) begin
         @(negedge clk);
         if (!uart_txd) hi_ok = 1'b0;
      end
      check("lb_txd_high", 32'(hi_ok), 32'h1);
      check("lb_irq", 32'(IRQ), 32'h1);
      bus_read(3'd1, rd); check("lb_rx_data", rd, 32'h8000005A);
      bus_write(3'd1, 32'h0);
      bus_write(3'd3, 32'h0);
`else
      bus_write(3'd3, 32'h5);
      bus_read(3'd3, rd); check("ctrl_no_lb", rd, 32'h1);
      bus_write(3'd3, 32'h0);
      hi_ok = 1'b1;
`endif

      // reset mid-frame forces the line high without waiting for a clock
      bus_write(3'd0, 32'h00);
      idle(20);
      check("mid_frame_low", 32'(uart_txd), 32'h0);
      #2 reset = 1'b0;
      #1 check("async_reset_txd", 32'(uart_txd), 32'h1);
      idle(2);
      reset = 1'b1;
      idle(2);
      bus_read(3'd2, rd); check("post_reset_status", rd, 32'h2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
